// File: rtl/truncate_sequencer_pkg.sv
// Shared definitions for the cluster truncator sequencer: pass index width,
// controller states and a saturating-increment helper for status counters.
package truncate_sequencer_pkg;

    localparam int PASS_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        RUN   = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sbit_delay_line.sv
// Fixed-depth shift register that aligns truncator-side tags with the encoder pipeline.
// DEPTH=0 degenerates to a wire so the tag appears in the same cycle.
module sbit_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk;
            assign unused_clk = clock ^ reset_n;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/truncate_sequencer.sv
// Per-crossing controller for the cluster truncator and pipelined priority encoder:
// latches the truncator, steps the pass index, tags passes for the encoder and tracks overflow/collisions.
module truncate_sequencer
    import truncate_sequencer_pkg::*;
#(
    parameter int PASSES_PER_BX = 4,
    parameter int ENC_LATENCY   = 3,
    parameter int CNT_W         = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              bx_strobe,
    input  logic              vpf_any,
    input  logic              cnt_clear,
    output logic              latch_pulse,
    output logic [PASS_W-1:0] pass,
    output logic              enc_capture,
    output logic [PASS_W-1:0] enc_pass,
    output logic              frame_done,
    output logic              overflow,
    output logic [CNT_W-1:0]  overflow_cnt,
    output logic [CNT_W-1:0]  collide_cnt,
    output state_t            fsm_state
);

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES_PER_BX - 1);
    localparam logic [31:0]       CNT_MAX   = 32'({CNT_W{1'b1}});
    localparam int                TAG_W     = PASS_W + 2;

    state_t              state, state_next;
    logic [PASS_W-1:0]   pass_next;
    logic                start, in_run, final_pass, collide, overflow_hit;
    logic [TAG_W-1:0]    tag_in, tag_out;
    logic [CNT_W-1:0]    overflow_cnt_next, collide_cnt_next;

    assign start      = bx_strobe & enable;
    assign in_run     = (state == RUN);
    assign final_pass = in_run && (pass == LAST_PASS);
    assign fsm_state  = state;

    // A strobe in the final pass is the normal back-to-back case; earlier strobes abort the window.
    always_comb begin
        state_next   = state;
        pass_next    = '0;
        collide      = 1'b0;
        overflow_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = LATCH;
            end
            LATCH: begin
                if (start) begin
                    state_next = LATCH;
                    collide    = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (pass == LAST_PASS) begin
                    overflow_hit = vpf_any;
                    state_next   = start ? LATCH : IDLE;
                end else if (start) begin
                    state_next = LATCH;
                    collide    = 1'b1;
                end else begin
                    state_next = RUN;
                    pass_next  = pass + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pass        <= '0;
            latch_pulse <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            pass        <= pass_next;
            latch_pulse <= (state_next == LATCH);
            overflow    <= overflow_hit;
        end
    end

    assign overflow_cnt_next = CNT_W'(sat_inc(32'(overflow_cnt), CNT_MAX));
    assign collide_cnt_next  = CNT_W'(sat_inc(32'(collide_cnt), CNT_MAX));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_cnt <= '0;
            collide_cnt  <= '0;
        end else begin
            if (cnt_clear)         overflow_cnt <= '0;
            else if (overflow_hit) overflow_cnt <= overflow_cnt_next;
            if (cnt_clear)         collide_cnt  <= '0;
            else if (collide)      collide_cnt  <= collide_cnt_next;
        end
    end

    // Tag word {capture, pass index, last-of-window} travels alongside the encoder pipeline.
    assign tag_in = {in_run & vpf_any,
                     in_run ? pass : {PASS_W{1'b0}},
                     in_run & ((pass == LAST_PASS) | start)};

    sbit_delay_line #(
        .WIDTH (TAG_W),
        .DEPTH (ENC_LATENCY)
    ) u_tag_line (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (tag_in),
        .q       (tag_out)
    );

    assign {enc_capture, enc_pass, frame_done} = tag_out;

endmodule
